// File: rtl/bm_crc_iter_unit.sv
// bm_crc_iter_unit: iterative reflected CRC-32 / CRC-32C unit for the
// bitmanip crc32{,c}.{b,h,w,d} group. Consumes BPC bits per cycle and uses
// valid/ready handshakes on the request and result sides.
// Optional build macro BM_CRC_PERF_EN adds a completed-op counter (ops_count_o).
module bm_crc_iter_unit #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned BPC         = 8,
  parameter logic [31:0] POLY_CRC32  = 32'hEDB88320,
  parameter logic [31:0] POLY_CRC32C = 32'h82F63B78
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      func_i,
  input  logic [XLEN-1:0] operand_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
`ifdef BM_CRC_PERF_EN
  ,
  output logic [31:0]     ops_count_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_state_next;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_result;
  logic            r_csel;
  logic [6:0]      r_cnt;
  logic [1:0]      w_size;
  logic [6:0]      w_cnt_init;
  logic [XLEN-1:0] w_poly_ext;
  logic [XLEN-1:0] w_x_step;
  logic            w_accept;
  logic            w_last;

  // A doubleword request on a 32-bit datapath runs as a word.
  assign w_size      = (XLEN == 32 && func_i[1:0] == 2'b11) ? 2'b10 : func_i[1:0];
  assign w_cnt_init  = (7'd8 << w_size) / 7'(BPC);
  assign in_ready_o  = (r_state == IDLE) && !rst_i && !flush_i;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_last      = (r_state == RUN) && (r_cnt == 7'd1);
  assign w_poly_ext  = XLEN'(r_csel ? POLY_CRC32C : POLY_CRC32);
  assign out_valid_o = (r_state == DONE);
  assign busy_o      = (r_state != IDLE);
  assign result_o    = r_result;

  // BPC unrolled reflected CRC shift steps on the working register
  always_comb begin
    logic [XLEN-1:0] v_x;
    v_x = r_x;
    for (int unsigned i = 0; i < BPC; i++) begin
      v_x = (v_x >> 1) ^ (w_poly_ext & {XLEN{v_x[0]}});
    end
    w_x_step = v_x;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept)    w_state_next = RUN;
        RUN:     if (w_last)      w_state_next = DONE;
        DONE:    if (out_ready_i) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Datapath: load on accept, shift while running, capture on the last step
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x      <= '0;
      r_csel   <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_x    <= operand_i;
      r_csel <= func_i[2];
      r_cnt  <= w_cnt_init;
    end else if (r_state == RUN && !flush_i) begin
      r_x   <= w_x_step;
      r_cnt <= r_cnt - 7'd1;
      if (w_last) r_result <= w_x_step;
    end
  end

`ifdef BM_CRC_PERF_EN
  logic [31:0] r_ops;
  assign ops_count_o = r_ops;

  // Count consumed results; flushed ones are dropped uncounted
  always_ff @(posedge clk_i) begin
    if (rst_i)                                      r_ops <= '0;
    else if (out_valid_o && out_ready_i && !flush_i) r_ops <= r_ops + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bm_crc_iter_unit.sv
// Bench for bm_crc_iter_unit: three instances (XLEN64/BPC8, XLEN64/BPC1,
// XLEN32/BPC8) share stimulus; directed table plus handshake/flush/reset sequences.
module tb_bm_crc_iter_unit;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  func;
  logic [63:0] operand;

  logic        a_irdy, a_ov, a_busy;
  logic [63:0] a_res;
  logic        b_irdy, b_ov, b_busy;
  logic [63:0] b_res;
  logic        c_irdy, c_ov, c_busy;
  logic [31:0] c_res;
`ifdef BM_CRC_PERF_EN
  logic [31:0] a_ops, b_ops, c_ops;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bm_crc_iter_unit #(.XLEN(64), .BPC(8)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(a_irdy), .func_i(func), .operand_i(operand),
    .out_valid_o(a_ov), .out_ready_i(out_ready), .result_o(a_res), .busy_o(a_busy)
`ifdef BM_CRC_PERF_EN
    , .ops_count_o(a_ops)
`endif
  );

  bm_crc_iter_unit #(.XLEN(64), .BPC(1)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(b_irdy), .func_i(func), .operand_i(operand),
    .out_valid_o(b_ov), .out_ready_i(out_ready), .result_o(b_res), .busy_o(b_busy)
`ifdef BM_CRC_PERF_EN
    , .ops_count_o(b_ops)
`endif
  );

  bm_crc_iter_unit #(.XLEN(32), .BPC(8)) u_c (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(c_irdy), .func_i(func), .operand_i(operand[31:0]),
    .out_valid_o(c_ov), .out_ready_i(out_ready), .result_o(c_res), .busy_o(c_busy)
`ifdef BM_CRC_PERF_EN
    , .ops_count_o(c_ops)
`endif
  );

  typedef struct {
    logic [2:0]  f;
    logic [63:0] op;
    logic [63:0] e64;
    logic [31:0] e32;
    int          la, lb, lc;
    bit          chk64;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request to all instances and record each one's latency
  task automatic do_op(input logic [2:0] f, input logic [63:0] op,
                       output int la, output int lb, output int lc);
    la = -1; lb = -1; lc = -1;
    @(negedge clk);
    func = f; operand = op; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (a_ov && la < 0) la = k;
      if (b_ov && lb < 0) lb = k;
      if (c_ov && lc < 0) lc = k;
      if (la >= 0 && lb >= 0 && lc >= 0) break;
    end
  endtask

  task automatic rel_out();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int la, lb, lc;
    bit seen;

    tv[0] = '{3'b000, 64'h80,                  64'hEDB88320,         32'hEDB88320, 1, 8,  1, 1'b1};
    tv[1] = '{3'b101, 64'h8000,                64'h82F63B78,         32'h82F63B78, 2, 16, 2, 1'b1};
    tv[2] = '{3'b011, 64'h8000000000000000,    64'hEDB88320,         32'h0,        8, 64, 4, 1'b1};
    tv[3] = '{3'b010, 64'h80000000,            64'hEDB88320,         32'hEDB88320, 4, 32, 4, 1'b1};
    tv[4] = '{3'b000, 64'h100,                 64'h1,                32'h1,        1, 8,  1, 1'b1};
    tv[5] = '{3'b000, 64'hFFFF000000000000,    64'h00FFFF0000000000, 32'h0,        1, 8,  1, 1'b1};
    tv[6] = '{3'b011, 64'h8000000080000000,    64'h0,                32'hEDB88320, 8, 64, 4, 1'b0};
    tv[7] = '{3'b100, 64'h80,                  64'h82F63B78,         32'h82F63B78, 1, 8,  1, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    func = '0; operand = '0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_result", a_res, 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_in_ready", 64'(a_irdy), 64'd0);
`ifdef BM_CRC_PERF_EN
    chk("rst_ops", 64'(a_ops), 64'd0);
`endif
    @(negedge clk); rst = 1'b0;
    #1 chk("idle_in_ready", 64'(a_irdy), 64'd1);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(tv[i].f, tv[i].op, la, lb, lc);
      if (tv[i].chk64) begin
        chk($sformatf("v%0d_res_a", i), a_res, tv[i].e64);
        chk($sformatf("v%0d_res_b", i), b_res, tv[i].e64);
      end
      chk($sformatf("v%0d_res_c", i), 64'(c_res), 64'(tv[i].e32));
      chk($sformatf("v%0d_lat_a", i), 64'(la), 64'(tv[i].la));
      chk($sformatf("v%0d_lat_b", i), 64'(lb), 64'(tv[i].lb));
      chk($sformatf("v%0d_lat_c", i), 64'(lc), 64'(tv[i].lc));
      rel_out();
    end

    // Back-pressure: result held while out_ready_i is low
    do_op(3'b000, 64'h80, la, lb, lc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(a_ov), 64'd1);
      chk("bp_result", a_res, 64'hEDB88320);
      chk("bp_in_ready", 64'(a_irdy), 64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", 64'(a_ov), 64'd0);
    chk("bp_rel_in_ready", 64'(a_irdy), 64'd1);
    chk("bp_rel_busy", 64'(a_busy), 64'd0);
    @(negedge clk); out_ready = 1'b0;

    // Request presented together with flush is discarded
    @(negedge clk);
    func = 3'b000; operand = 64'h80; in_valid = 1'b1; flush = 1'b1;
    #1 chk("fl_req_in_ready", 64'(a_irdy), 64'd0);
    @(posedge clk); #1;
    chk("fl_req_busy", 64'(a_busy), 64'd0);
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;

    // Flush mid-RUN on the BPC=1 instance; the BPC=8 one is flushed in DONE
    @(negedge clk);
    func = 3'b010; operand = 64'h80000000; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      if (b_ov) seen = 1'b1;
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    if (b_ov) seen = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1;
    chk("fl_run_busy", 64'(b_busy), 64'd0);
    chk("fl_run_in_ready", 64'(b_irdy), 64'd1);
    chk("fl_run_valid_seen", 64'(seen), 64'd0);
    chk("fl_done_valid", 64'(a_ov), 64'd0);
    chk("fl_done_result_held", a_res, 64'hEDB88320);
    do_op(3'b000, 64'h0, la, lb, lc);
    chk("fl_after_res_b", b_res, 64'd0);
    chk("fl_after_lat_b", 64'(lb), 64'd8);
    chk("fl_after_res_a", a_res, 64'd0);
    rel_out();

    // Reset asserted in DONE after three counted ops
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_op(3'b000, 64'h80, la, lb, lc);
      rel_out();
    end
`ifdef BM_CRC_PERF_EN
    chk("perf_ops3", 64'(a_ops), 64'd3);
`endif
    do_op(3'b010, 64'h80000000, la, lb, lc);
    chk("rst_pre_valid", 64'(a_ov), 64'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rstd_valid", 64'(a_ov), 64'd0);
    chk("rstd_result", a_res, 64'd0);
    chk("rstd_busy", 64'(a_busy), 64'd0);
    chk("rstd_in_ready", 64'(a_irdy), 64'd0);
`ifdef BM_CRC_PERF_EN
    chk("rstd_ops", 64'(a_ops), 64'd0);
`endif
    @(negedge clk); rst = 1'b0;
    #1 chk("rstd_idle_in_ready", 64'(a_irdy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
